thumb_shift_issue: RTL and testbench

- Issue/writeback controller, the initiator side of the shift execution unit's interface.
- Accepts 16-bit Thumb shift/move instructions, decodes them and reads operands from the register file.
- Drives the shift unit (en_inst/S/Rm/operand2/stype), waits for its result, then writes Rd and updates the NZC flags it owns.
- Sits between fetch and the register file in the cortex-m0 core.

---
 rtl/cm0_shift_pkg.sv | 37 +++
 rtl/thumb_shift_issue_if.sv | 25 ++
 rtl/thumb_shift_decode.sv | 38 +++
 rtl/thumb_shift_issue.sv | 147 ++++++++++++++
 tb/tb_thumb_shift_issue.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cm0_shift_pkg.sv
// Shared shift-type codes, Thumb opcode fields, FSM states and decode record
// for the Thumb shift issue/writeback controller.
package cm0_shift_pkg;

  localparam logic [1:0] LSL = 2'b00;
  localparam logic [1:0] LSR = 2'b01;
  localparam logic [1:0] ASR = 2'b10;

  localparam logic [4:0] OP_LSL_IMM = 5'b00000;
  localparam logic [4:0] OP_LSR_IMM = 5'b00001;
  localparam logic [4:0] OP_ASR_IMM = 5'b00010;

  localparam logic [9:0] OP_LSL_REG = 10'b0100000010;
  localparam logic [9:0] OP_LSR_REG = 10'b0100000011;
  localparam logic [9:0] OP_ASR_REG = 10'b0100000100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_SRC,
    ST_RD_AMT,
    ST_ISSUE,
    ST_WAIT,
    ST_WB
  } state_t;

  // rs: register shifted (Rm or Rdn); ra: register holding the amount (reg form)
  typedef struct packed {
    logic       legal;
    logic       is_reg;
    logic [1:0] stype;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [2:0] ra;
    logic [7:0] imm_amt;
  } dec_t;

endpackage

// File: rtl/thumb_shift_issue_if.sv
// Request/response bundle between the issue controller and the shift unit.
interface thumb_shift_issue_if;
  logic        sh_en;
  logic        sh_s;
  logic [31:0] sh_rm;
  logic [7:0]  sh_amt;
  logic [1:0]  sh_stype;
  logic        sh_cin;
  logic        sh_zin;
  logic        sh_nin;
  logic [31:0] sh_rd;
  logic        sh_c;
  logic        sh_z;
  logic        sh_n;

  modport master (
    output sh_en, sh_s, sh_rm, sh_amt, sh_stype, sh_cin, sh_zin, sh_nin,
    input  sh_rd, sh_c, sh_z, sh_n
  );

  modport slave (
    input  sh_en, sh_s, sh_rm, sh_amt, sh_stype, sh_cin, sh_zin, sh_nin,
    output sh_rd, sh_c, sh_z, sh_n
  );
endinterface

// File: rtl/thumb_shift_decode.sv
// Combinational decode of 16-bit Thumb LSL/LSR/ASR (immediate and register forms).
module thumb_shift_decode
  import cm0_shift_pkg::*;
(
  input  logic [15:0] inst,
  output dec_t        dec
);

  always_comb begin
    dec    = '0;
    dec.rd = inst[2:0];
    dec.ra = inst[5:3];
    case (inst[15:11])
      OP_LSL_IMM: begin dec.legal = 1'b1; dec.stype = LSL; end
      OP_LSR_IMM: begin dec.legal = 1'b1; dec.stype = LSR; end
      OP_ASR_IMM: begin dec.legal = 1'b1; dec.stype = ASR; end
      default:    dec.legal = 1'b0;
    endcase

    if (dec.legal) begin
      dec.rs      = inst[5:3];
      dec.imm_amt = {3'b000, inst[10:6]};
      // LSR/ASR encode a shift of 32 as zero; LSL #0 stays zero (MOVS)
      if (inst[10:6] == 5'd0 && dec.stype != LSL)
        dec.imm_amt = 8'd32;
    end else begin
      dec.rs     = inst[2:0];
      dec.is_reg = 1'b1;
      case (inst[15:6])
        OP_LSL_REG: begin dec.legal = 1'b1; dec.stype = LSL; end
        OP_LSR_REG: begin dec.legal = 1'b1; dec.stype = LSR; end
        OP_ASR_REG: begin dec.legal = 1'b1; dec.stype = ASR; end
        default:    dec.is_reg = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/thumb_shift_issue.sv
// Issue/writeback controller for Thumb shift instructions: reads operands, drives the
// shift unit, writes Rd and NZC. THUMB_MOVS_BYPASS_EN lets MOVS skip the shift unit.
module thumb_shift_issue
  import cm0_shift_pkg::*;
#(
  parameter int unsigned SH_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  input  logic [15:0] inst,
  output logic        inst_ready,
  output logic        inst_done,
  output logic        undef,
  output logic [3:0]  rf_raddr,
  input  logic [31:0] rf_rdata,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  thumb_shift_issue_if.master sh,
  output logic        flag_c,
  output logic        flag_z,
  output logic        flag_n
);

  state_t     state;
  dec_t       dec;
  logic [3:0] cnt;
  logic [2:0] rd_q;
  logic [2:0] ra_q;
  logic       is_reg_q;
`ifdef THUMB_MOVS_BYPASS_EN
  logic       movs_q;
`endif

  thumb_shift_decode u_dec (
    .inst (inst),
    .dec  (dec)
  );

  assign sh.sh_s   = 1'b1;
  assign sh.sh_cin = flag_c;
  assign sh.sh_zin = flag_z;
  assign sh.sh_nin = flag_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      rd_q        <= '0;
      ra_q        <= '0;
      is_reg_q    <= 1'b0;
`ifdef THUMB_MOVS_BYPASS_EN
      movs_q      <= 1'b0;
`endif
      inst_ready  <= 1'b1;
      inst_done   <= 1'b0;
      undef       <= 1'b0;
      rf_raddr    <= '0;
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      sh.sh_en    <= 1'b0;
      sh.sh_rm    <= '0;
      sh.sh_amt   <= '0;
      sh.sh_stype <= LSL;
      flag_c      <= 1'b0;
      flag_z      <= 1'b0;
      flag_n      <= 1'b0;
    end else begin
      inst_done <= 1'b0;
      undef     <= 1'b0;
      rf_we     <= 1'b0;
      sh.sh_en  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (inst_valid && inst_ready) begin
            if (!dec.legal) begin
              undef <= 1'b1;
            end else begin
              state       <= ST_RD_SRC;
              inst_ready  <= 1'b0;
              rd_q        <= dec.rd;
              ra_q        <= dec.ra;
              is_reg_q    <= dec.is_reg;
`ifdef THUMB_MOVS_BYPASS_EN
              movs_q      <= !dec.is_reg && dec.stype == LSL && dec.imm_amt == '0;
`endif
              rf_raddr    <= {1'b0, dec.rs};
              sh.sh_stype <= dec.stype;
              sh.sh_amt   <= dec.imm_amt;
            end
          end
        end
        ST_RD_SRC: begin
          sh.sh_rm <= rf_rdata;
`ifdef THUMB_MOVS_BYPASS_EN
          if (movs_q) begin
            state     <= ST_WB;
            rf_we     <= 1'b1;
            inst_done <= 1'b1;
            rf_waddr  <= {1'b0, rd_q};
            rf_wdata  <= rf_rdata;
            flag_n    <= rf_rdata[31];
            flag_z    <= (rf_rdata == '0);
          end else
`endif
          if (is_reg_q) begin
            state    <= ST_RD_AMT;
            rf_raddr <= {1'b0, ra_q};
          end else begin
            state    <= ST_ISSUE;
            sh.sh_en <= 1'b1;
          end
        end
        ST_RD_AMT: begin
          sh.sh_amt <= rf_rdata[7:0];
          sh.sh_en  <= 1'b1;
          state     <= ST_ISSUE;
        end
        ST_ISSUE: begin
          cnt   <= 4'(SH_LAT);
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state     <= ST_WB;
            rf_we     <= 1'b1;
            inst_done <= 1'b1;
            rf_waddr  <= {1'b0, rd_q};
            rf_wdata  <= sh.sh_rd;
            flag_c    <= sh.sh_c;
            flag_z    <= sh.sh_z;
            flag_n    <= sh.sh_n;
          end
        end
        ST_WB: begin
          state      <= ST_IDLE;
          inst_ready <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_thumb_shift_issue.sv
// Scoreboard bench for thumb_shift_issue: register file and shift unit stand-ins,
// a reference model of the instruction set, and a monitor comparing writebacks.
module tb_thumb_shift_issue;

  localparam int unsigned LAT = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_valid = 1'b0;
  logic [15:0] inst = '0;
  logic        inst_ready, inst_done, undef;
  logic [3:0]  rf_raddr, rf_waddr;
  logic [31:0] rf_rdata, rf_wdata;
  logic        rf_we;
  logic        flag_c, flag_z, flag_n;

  thumb_shift_issue_if shi ();

  thumb_shift_issue #(.SH_LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_ready (inst_ready),
    .inst_done  (inst_done),
    .undef      (undef),
    .rf_raddr   (rf_raddr),
    .rf_rdata   (rf_rdata),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .sh         (shi),
    .flag_c     (flag_c),
    .flag_z     (flag_z),
    .flag_n     (flag_n)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_undef;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic        c, z, n;
    logic [31:0] cyc;
  } exp_t;

  typedef struct packed {
    logic [31:0] rm;
    logic [7:0]  amt;
    logic [1:0]  st;
    logic        c, z, n;
  } iss_t;

  exp_t sbq[$];
  iss_t isq[$];

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [31:0] cyc   = '0;
  logic [31:0] rf [8];
  logic [31:0] mr [8];
  logic        mc = 1'b0, mz = 1'b0, mn = 1'b0;
  int unsigned k = 0;
  logic        prev_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 32'd1;

  assign rf_rdata = rf_raddr[3] ? 32'hBAD0BAD0 : rf[rf_raddr[2:0]];
  always @(posedge clk) if (rf_we) rf[rf_waddr[2:0]] <= rf_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ARM barrel-shifter semantics via a 64-bit window: carry is the last bit shifted out
  function automatic logic [32:0] shref(input logic [31:0] v, input logic [7:0] n,
                                        input logic [1:0] st, input logic cin);
    logic [63:0] w;
    if (n == 8'd0) return {cin, v};
    case (st)
      2'b00: begin w = {32'b0, v} << n; return {w[32], w[31:0]}; end
      2'b01: begin w = {v, 32'b0} >> n; return {w[31], w[63:32]}; end
      default: begin w = $signed({v, 32'b0}) >>> n; return {w[31], w[63:32]}; end
    endcase
  endfunction

  task automatic model(input logic [15:0] x, output exp_t e, output bit to_sh,
                       output iss_t is, output int unsigned lat);
    logic [1:0]  st;
    logic [7:0]  n;
    logic [2:0]  src, d;
    logic [32:0] r;
    bit          legal, isreg;
    legal = 0; isreg = 0; st = 2'b00; n = '0; d = x[2:0]; src = x[5:3];
    e = '0; is = '0; to_sh = 0; lat = 1;
    if (x[15:11] <= 5'd2) begin
      legal = 1; st = x[12:11]; n = {3'b000, x[10:6]};
      if (n == 8'd0 && st != 2'b00) n = 8'd32;
    end else if (x[15:6] >= 10'h102 && x[15:6] <= 10'h104) begin
      legal = 1; isreg = 1; st = 2'(x[15:6] - 10'h102); src = x[2:0];
      n = mr[x[5:3]][7:0];
    end
    if (!legal) begin
      e.is_undef = 1'b1;
      return;
    end
    is.rm = mr[src]; is.amt = n; is.st = st; is.c = mc; is.z = mz; is.n = mn;
    to_sh = 1; lat = isreg ? 5 : 4;
`ifdef THUMB_MOVS_BYPASS_EN
    if (!isreg && st == 2'b00 && n == 8'd0) begin to_sh = 0; lat = 2; end
`endif
    r = shref(mr[src], n, st, mc);
    e.waddr = {1'b0, d}; e.wdata = r[31:0];
    e.c = r[32]; e.z = (r[31:0] == '0); e.n = r[31];
    mr[d] = r[31:0]; mc = e.c; mz = e.z; mn = e.n;
  endtask

  // Shift unit stand-in: result is valid only in the cycle the DUT must sample it
  always @(negedge clk) begin : shunit
    logic [32:0] r;
    r = {1'($urandom), $urandom};
    if (!rst) k = 0;
    else begin
      if (k != 0) begin
        k--;
        if (k == 0) r = shref(shi.sh_rm, shi.sh_amt, shi.sh_stype, shi.sh_cin);
      end
      if (shi.sh_en) k = LAT;
    end
    shi.sh_rd = r[31:0]; shi.sh_c = r[32]; shi.sh_z = (r[31:0] == '0); shi.sh_n = r[31];
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    iss_t s;
    if (rst) begin
      if (rf_we || inst_done || undef) begin
        if (sbq.size() == 0) begin
          chk("unexpected_output", {29'b0, rf_we, inst_done, undef}, 32'd0);
        end else begin
          e = sbq.pop_front();
          if (e.is_undef) begin
            chk("undef", 32'(undef), 32'd1);
            chk("undef_we", 32'(rf_we), 32'd0);
            chk("undef_ready", 32'(inst_ready), 32'd1);
            chk("undef_flags", {29'b0, flag_n, flag_z, flag_c}, {29'b0, mn, mz, mc});
          end else begin
            chk("wb_we", 32'(rf_we), 32'd1);
            chk("wb_done", 32'(inst_done), 32'd1);
            chk("wb_undef", 32'(undef), 32'd0);
            chk("wb_addr", 32'(rf_waddr), 32'(e.waddr));
            chk("wb_data", rf_wdata, e.wdata);
            chk("wb_nzc", {29'b0, flag_n, flag_z, flag_c}, {29'b0, e.n, e.z, e.c});
          end
          chk("latency", cyc, e.cyc);
        end
      end
      if (shi.sh_en) begin
        chk("sh_en_pulse", 32'(prev_en), 32'd0);
        if (isq.size() == 0) begin
          chk("unexpected_sh_en", 32'(shi.sh_en), 32'd0);
        end else begin
          s = isq.pop_front();
          chk("sh_rm", shi.sh_rm, s.rm);
          chk("sh_amt", 32'(shi.sh_amt), 32'(s.amt));
          chk("sh_stype", 32'(shi.sh_stype), 32'(s.st));
          chk("sh_s", 32'(shi.sh_s), 32'd1);
          chk("sh_flags_in", {29'b0, shi.sh_nin, shi.sh_zin, shi.sh_cin}, {29'b0, s.n, s.z, s.c});
        end
      end
    end
    prev_en = shi.sh_en;
  end

  task automatic send(input logic [15:0] x);
    exp_t e; iss_t is; bit to_sh; int unsigned lat; int unsigned guard;
    guard = 0;
    while (!inst_ready && guard < 60) begin @(negedge clk); guard++; end
    chk("ready_before_send", 32'(inst_ready), 32'd1);
    @(negedge clk);
    inst = x; inst_valid = 1'b1;
    model(x, e, to_sh, is, lat);
    @(posedge clk); #1;
    e.cyc = cyc + 32'(lat) - 32'd1;
    sbq.push_back(e);
    if (to_sh) isq.push_back(is);
    inst_valid = 1'b0; inst = 16'($urandom);
  endtask

  task automatic drain();
    int unsigned guard;
    guard = 0;
    while ((sbq.size() != 0 || !inst_ready) && guard < 60) begin @(negedge clk); guard++; end
    chk("drain", 32'(sbq.size()), 32'd0);
  endtask

  task automatic issue(input logic [15:0] x);
    send(x);
    drain();
  endtask

  task automatic check_reset_state();
    chk("rst_ready", 32'(inst_ready), 32'd1);
    chk("rst_pulses", {29'b0, inst_done, undef, rf_we}, 32'd0);
    chk("rst_raddr", 32'(rf_raddr), 32'd0);
    chk("rst_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_sh_en", 32'(shi.sh_en), 32'd0);
    chk("rst_sh_rm", shi.sh_rm, 32'd0);
    chk("rst_sh_amt", {22'b0, shi.sh_amt, shi.sh_stype}, 32'd0);
    chk("rst_flags", {29'b0, flag_n, flag_z, flag_c}, 32'd0);
  endtask

  task automatic seed_regs();
    for (int i = 0; i < 8; i++) begin
      mr[i] = $urandom_range(0, 1) ? 32'($urandom_range(0, 40)) : $urandom;
      rf[i] = mr[i];
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [31:0] save [8];
    logic [15:0] x;
    int unsigned guard;
    seed_regs();
    mr[2] = 32'h8000000F; mr[3] = 32'h80000000; mr[4] = 32'h1; mr[5] = 32'h101; mr[7] = 32'h0;
    for (int i = 0; i < 8; i++) rf[i] = mr[i];

    #1 rst = 1'b0;
    #1 check_reset_state();
    repeat (3) @(negedge clk);
    rst = 1'b1;

    issue(16'h0111);   // LSLS r1,r2,#4
    issue(16'h1018);   // ASRS r0,r3,#32
    issue(16'h40EC);   // LSRS r4,r5
    issue(16'h1800);   // undefined

    // reset while waiting on the shift unit
    save = mr;
    send(16'h0111);
    guard = 0;
    while (!shi.sh_en && guard < 20) begin @(negedge clk); guard++; end
    @(negedge clk);
    rst = 1'b0;
    #1 check_reset_state();
    sbq.delete(); isq.delete();
    mr = save; mc = 1'b0; mz = 1'b0; mn = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    issue(16'h0111);
    issue(16'h003E);   // MOVS r6,r7 with r7 == 0

    for (int n = 0; n < 160; n++) begin
      if (n % 40 == 0) seed_regs();
      case ($urandom_range(0, 4))
        0, 1:    x = {3'b000, 2'($urandom_range(0, 2)), 11'($urandom)};
        2:       x = {10'h102 + 10'($urandom_range(0, 2)), 6'($urandom)};
        3:       x = {10'b0, 6'($urandom)};
        default: x = 16'($urandom);
      endcase
      issue(x);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    chk("issue_q_empty", 32'(isq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
